// File: rtl/i2c_master.sv
// Single-byte I2C master (write one byte or read one byte per transfer).
//
// Each bit slot is four divider ticks: SCL low in phases 0-1, high in 2-3.
// SDA is only changed at phase 0 and sampled on entry to phase 2. START and
// STOP use two ticks each.
//
// Ports:
//   clk_50   system clock, rising edge
//   reset    asynchronous active-high reset
//   start    one-cycle transfer request, honoured only when idle
//   addr     7-bit slave address (captured with start)
//   rw       0 = write, 1 = read (captured with start)
//   wdata    byte to write (captured with start)
//   rdata    last byte read, MSB first
//   busy     transfer in progress
//   done     one-cycle pulse on return to idle after STOP
//   ack_err  slave NACKed; valid with done, cleared on the next start
//   scl      I2C clock (push-pull)
//   sda      I2C data, open-drain (0 or Z)
module i2c_master #(
    parameter int unsigned DIV = 125
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DivLast = DW'(DIV - 1);

    typedef enum logic [3:0] {
        StIdle, StStart, StAddr, StAddrAck, StWrite, StWriteAck, StRead, StReadAck, StStop
    } state_t;

    state_t      state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]  phase_q, phase_d;
    logic [2:0]  bit_q, bit_d;
    logic [6:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        ack_err_q, ack_err_d;
    logic        done_q, done_d;

    logic        tick;
    logic        end_slot;
    logic        sample;
    logic [1:0]  last_phase;
    logic        sda_low;
    logic        sda_in;
    logic [7:0]  addr_byte;

    assign sda       = sda_low ? 1'b0 : 1'bz;
    assign sda_in    = sda;
    assign busy      = (state_q != StIdle);
    assign rdata     = rdata_q;
    assign done      = done_q;
    assign ack_err   = ack_err_q;
    assign addr_byte = {addr_q, rw_q};

    assign tick       = busy && (div_q == DivLast);
    // START and STOP occupy only two ticks; data/ack slots use all four.
    assign last_phase = (state_q == StStart || state_q == StStop) ? 2'd1 : 2'd3;
    assign end_slot   = tick && (phase_q == last_phase);
    assign sample     = tick && (phase_q == 2'd1);

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            div_q     <= '0;
            phase_q   <= '0;
            bit_q     <= '0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        sda_low   = 1'b0;
        scl       = 1'b1;

        if (!busy || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        if (tick) begin
            phase_d = (phase_q == last_phase) ? 2'd0 : phase_q + 2'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d    = addr;
                    rw_d      = rw;
                    wdata_d   = wdata;
                    ack_err_d = 1'b0;
                    phase_d   = 2'd0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                sda_low = 1'b1;
                if (end_slot) begin
                    bit_d   = 3'd7;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                scl     = phase_q[1];
                sda_low = !addr_byte[bit_q];
                if (end_slot) begin
                    if (bit_q == 3'd0) state_d = StAddrAck;
                    else               bit_d   = bit_q - 3'd1;
                end
            end
            StAddrAck: begin
                scl = phase_q[1];
                if (sample && sda_in) ack_err_d = 1'b1;
                // ack_err_q already holds this slot's sample by the end of the slot.
                if (end_slot) begin
                    bit_d = 3'd7;
                    if (ack_err_q)  state_d = StStop;
                    else if (rw_q)  state_d = StRead;
                    else            state_d = StWrite;
                end
            end
            StWrite: begin
                scl     = phase_q[1];
                sda_low = !wdata_q[bit_q];
                if (end_slot) begin
                    if (bit_q == 3'd0) state_d = StWriteAck;
                    else               bit_d   = bit_q - 3'd1;
                end
            end
            StWriteAck: begin
                scl = phase_q[1];
                if (sample && sda_in) ack_err_d = 1'b1;
                if (end_slot) state_d = StStop;
            end
            StRead: begin
                scl = phase_q[1];
                if (sample) rx_d = {rx_q[6:0], sda_in};
                if (end_slot) begin
                    if (bit_q == 3'd0) begin
                        rdata_d = rx_q;
                        state_d = StReadAck;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            StReadAck: begin
                // Released SDA is a NACK: only one byte is ever read.
                scl = phase_q[1];
                if (end_slot) state_d = StStop;
            end
            StStop: begin
                // Phase 0: SCL low, SDA low; phase 1: SCL high; release on exit.
                sda_low = 1'b1;
                scl     = phase_q[0];
                if (end_slot) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a small behavioural I2C slave on the bus.
module tb_i2c_master;
    localparam int unsigned DIV = 4;
    localparam int FullCyc = 76 * DIV + 1;
    localparam int NackCyc = 40 * DIV + 1;

    logic       clk_50 = 1'b0;
    logic       reset  = 1'b1;
    logic       start  = 1'b0;
    logic [6:0] addr   = '0;
    logic       rw     = 1'b0;
    logic [7:0] wdata  = '0;
    logic [7:0] rdata;
    logic       busy, done, ack_err, scl;
    wire        sda;

    int checks = 0;
    int errors = 0;

    // Slave configuration (main process) and slave/monitor state (monitor process).
    logic       sl_ack_addr = 1'b1;
    logic       sl_ack_data = 1'b1;
    logic [7:0] sl_rd_byte  = 8'h00;
    int         clr_seq     = 0;

    logic       slave_low = 1'b0;
    int         clr_seen = 0;
    int         rises = 0;
    int         hi_changes = 0;
    int         pmin = 1000;
    int         pmax = 0;
    int         last_rise = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    logic       bits [32];
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       cur_scl, cur_sda;

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    i2c_master #(.DIV(DIV)) dut (
        .clk_50  (clk_50),
        .reset   (reset),
        .start   (start),
        .addr    (addr),
        .rw      (rw),
        .wdata   (wdata),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .scl     (scl),
        .sda     (sda)
    );

    always #5 clk_50 = ~clk_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bus_byte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[7-i] = bits[base+i];
        return b;
    endfunction

    // Bus monitor and slave, sampled 1 time unit after each falling clk edge.
    initial begin
        int p;
        for (int i = 0; i < 32; i++) bits[i] = 1'b0;
        forever begin
            @(negedge clk_50);
            #1;
            cyc++;
            cur_scl = scl;
            cur_sda = sda;
            if (clr_seen != clr_seq) begin
                clr_seen   = clr_seq;
                rises      = 0;
                hi_changes = 0;
                pmin       = 1000;
                pmax       = 0;
                done_cnt   = 0;
                slave_low  = 1'b0;
                for (int i = 0; i < 32; i++) bits[i] = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (prev_scl && cur_scl && (prev_sda != cur_sda)) begin
                    hi_changes++;
                    if (!cur_sda) rises = 0;  // START condition
                end
                if (!prev_scl && cur_scl) begin
                    if (rises >= 1 && rises <= 17) begin
                        p = cyc - last_rise;
                        if (p < pmin) pmin = p;
                        if (p > pmax) pmax = p;
                    end
                    last_rise = cyc;
                    if (rises < 32) bits[rises] = cur_sda;
                    rises++;
                end
                if (prev_scl && !cur_scl) begin
                    // Decide what the slave drives for the next bit slot.
                    if (rises == 8)
                        slave_low = sl_ack_addr;
                    else if (rises >= 9 && rises <= 16 && bits[7])
                        slave_low = !sl_rd_byte[16-rises];
                    else if (rises == 17 && !bits[7])
                        slave_low = sl_ack_data;
                    else
                        slave_low = 1'b0;
                end
            end
            prev_scl = cur_scl;
            prev_sda = cur_sda;
        end
    end

    // Call at a falling clk edge. Optionally pulses a conflicting start after
    // inject_at SCL rises.
    task automatic xfer(input logic [6:0] a, input logic r, input logic [7:0] w,
                        input int exp_cyc, input int inject_at, input string tag);
        int  n;
        bit  injected;
        injected = 1'b0;
        addr  = a;
        rw    = r;
        wdata = w;
        start = 1'b1;
        clr_seq++;
        @(negedge clk_50);
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_ackerr_clr"}, 32'(ack_err), 32'd0);
        n = 1;
        while (!done && n < 2000) begin
            @(negedge clk_50);
            n++;
            start = 1'b0;
            if (inject_at >= 0 && !injected && rises >= inject_at && !done) begin
                addr     = 7'h11;
                rw       = 1'b1;
                wdata    = 8'hFF;
                start    = 1'b1;
                injected = 1'b1;
            end
        end
        start = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_len"}, 32'(n >= exp_cyc - 1 && n <= exp_cyc + 1), 32'd1);
        @(negedge clk_50);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        #2;
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ackerr", 32'(ack_err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'h00);
        @(negedge clk_50);
        @(negedge clk_50);
        reset = 1'b0;
        @(negedge clk_50);

        // Write 0x50 / 0xA5, both ACKed.
        sl_ack_addr = 1'b1;
        sl_ack_data = 1'b1;
        xfer(7'h50, 1'b0, 8'hA5, FullCyc, -1, "wr");
        check("wr_addr_byte", 32'(bus_byte(0)), 32'hA0);
        check("wr_addr_ack", 32'(bits[8]), 32'd0);
        check("wr_data_byte", 32'(bus_byte(9)), 32'hA5);
        check("wr_data_ack", 32'(bits[17]), 32'd0);
        check("wr_ackerr", 32'(ack_err), 32'd0);
        check("wr_rises", 32'(rises), 32'd19);
        check("wr_sda_hi_changes", 32'(hi_changes), 32'd2);
        check("wr_scl_pmin", 32'(pmin), 32'd16);
        check("wr_scl_pmax", 32'(pmax), 32'd16);
        check("wr_done_cnt", 32'(done_cnt), 32'd1);

        // Address NACK: no data bits, straight to STOP.
        sl_ack_addr = 1'b0;
        xfer(7'h22, 1'b0, 8'h77, NackCyc, -1, "nack");
        check("nack_ackerr", 32'(ack_err), 32'd1);
        check("nack_addr_byte", 32'(bus_byte(0)), 32'h44);
        check("nack_ack_bit", 32'(bits[8]), 32'd1);
        check("nack_rises", 32'(rises), 32'd10);
        check("nack_sda_hi_changes", 32'(hi_changes), 32'd2);

        // Read 0x50, slave returns 0x3C; master NACKs.
        sl_ack_addr = 1'b1;
        sl_rd_byte  = 8'h3C;
        xfer(7'h50, 1'b1, 8'h00, FullCyc, -1, "rd");
        check("rd_rdata", 32'(rdata), 32'h3C);
        check("rd_ackerr", 32'(ack_err), 32'd0);
        check("rd_addr_byte", 32'(bus_byte(0)), 32'hA1);
        check("rd_master_nack", 32'(bits[17]), 32'd1);
        check("rd_sda_hi_changes", 32'(hi_changes), 32'd2);

        // Second start during WRITE must be ignored.
        xfer(7'h50, 1'b0, 8'h96, FullCyc, 11, "ign");
        check("ign_addr_byte", 32'(bus_byte(0)), 32'hA0);
        check("ign_data_byte", 32'(bus_byte(9)), 32'h96);
        repeat (40) @(negedge clk_50);
        check("ign_still_idle", 32'(busy), 32'd0);
        check("ign_done_cnt", 32'(done_cnt), 32'd1);

        // Reset during READ bit 4.
        @(negedge clk_50);
        addr  = 7'h50;
        rw    = 1'b1;
        start = 1'b1;
        clr_seq++;
        @(negedge clk_50);
        start = 1'b0;
        n = 0;
        while (rises < 13 && n < 2000) begin
            @(negedge clk_50);
            n++;
        end
        check("rst_mid_reached", 32'(rises >= 13), 32'd1);
        #3 reset = 1'b1;
        #1;
        check("rstm_scl", 32'(scl), 32'd1);
        check("rstm_sda", 32'(sda), 32'd1);
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_done", 32'(done), 32'd0);
        check("rstm_rdata", 32'(rdata), 32'h00);
        @(negedge clk_50);
        reset = 1'b0;
        xfer(7'h3A, 1'b0, 8'h5C, FullCyc, -1, "post");
        check("post_addr_byte", 32'(bus_byte(0)), 32'h74);
        check("post_data_byte", 32'(bus_byte(9)), 32'h5C);
        check("post_ackerr", 32'(ack_err), 32'd0);
        check("post_rises", 32'(rises), 32'd19);
        check("post_sda_hi_changes", 32'(hi_changes), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter DIV, default 125, meaning clk_50 cycles per quarter-bit (100 kHz SCL at 50 MHz).
REQ-002 SHALL have port clk_50, input, 1, the single system clock; all sequential logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, one-cycle transfer request; sampled only in IDLE.
REQ-005 SHALL have port addr, input, 7, slave address; captured with start.
REQ-006 SHALL have port rw, input, 1, 0 = write, 1 = read; captured with start.
REQ-007 SHALL have port wdata, input, 8, write byte; captured with start.
REQ-008 SHALL have port rdata, output, 8, last byte read, MSB first.
REQ-009 SHALL have port busy, output, 1, high from the cycle after an accepted start until return to IDLE.
REQ-010 SHALL have port done, output, 1, one-cycle pulse on entry to IDLE after STOP.
REQ-011 SHALL have port ack_err, output, 1, set when the slave NACKs; valid with done; cleared on the next accepted start.
REQ-012 SHALL have port scl, output, 1, I2C clock; drives only 0 or 1.
REQ-013 SHALL have port sda, inout, 1, open-drain: driven 0 or released to Z, never driven 1.

Function
REQ-014 SHALL generate a tick every DIV clk_50 cycles while busy; the divider SHALL be held at 0 in IDLE.
REQ-015 SHALL divide each bit into 4 tick phases: scl low in phases 0-1, high in 2-3; SDA changes only at phase 0; SDA sampled at phase 2 entry.
REQ-016 SHALL implement states IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP.
REQ-017 IDLE: scl=1, sda=Z; start=1 captures addr/rw/wdata, clears ack_err, goes to START.
REQ-018 START: with scl=1, sda pulled 0 for 2 ticks, then scl=0; goes to ADDR.
REQ-019 ADDR: shifts {addr,rw} out MSB first, 8 bits; goes to ADDR_ACK.
REQ-020 ADDR_ACK: sda released; sampled 0 goes to WRITE (rw=0) or READ (rw=1); sampled 1 sets ack_err and goes to STOP.
REQ-021 WRITE: shifts wdata MSB first, 8 bits; then WRITE_ACK.
REQ-022 WRITE_ACK: sda released; sampled 1 sets ack_err; always goes to STOP.
REQ-023 READ: sda released; samples 8 bits into a shift register MSB first; rdata updated once, after bit 0.
REQ-024 READ_ACK: master releases sda (NACK, single-byte read); goes to STOP.
REQ-025 STOP: sda=0 with scl low, scl raised, then sda released while scl=1 (2 ticks); goes to IDLE asserting done.
REQ-026 start asserted while busy SHALL be ignored, with no captured-field change.
REQ-027 A transfer SHALL take exactly 2+8+1+8+1+2 bit-slots of 4 ticks ±1 cycle (START/STOP counted as 2 ticks each).
REQ-028 The bit counter SHALL count 7 down to 0 and SHALL NOT wrap; exit occurs at 0.

Reset
REQ-029 reset SHALL immediately (no clock) force IDLE, scl=1, sda=Z, busy=0, done=0, ack_err=0, rdata=8'h00, divider and bit counter to 0.
REQ-030 reset mid-transfer SHALL abandon the transfer without generating STOP; start is accepted on the first clk_50 after reset falls.

Verification
REQ-031 Write addr=7'h50, wdata=8'hA5, slave ACKs both -> sda bits 1010000_0, ACK, 10100101, ACK, STOP; done pulse, ack_err=0.
REQ-032 Write addr=7'h22, slave NACKs address -> ack_err=1, no data bits clocked, STOP follows ADDR_ACK, done pulses.
REQ-033 Read addr=7'h50, slave drives 8'h3C -> rdata=8'h3C at done, master NACK on 9th bit, ack_err=0.
REQ-034 start pulsed again mid-WRITE with addr=7'h11 -> ignored; transfer completes to original address, single done.
REQ-035 reset asserted during READ bit 4 -> within the same cycle scl=1, sda=Z, busy=0; next start runs a full clean transfer.
REQ-036 DIV=4, full write -> SCL period exactly 16 clk_50 cycles; SDA never changes while scl=1 except at START/STOP.
